// File: rtl/onehot_encoder8_serial_if.sv
// Handshake bundle between an activation-vector producer and the serial one-hot encoder.
// The master modport is the side that offers vectors and consumes codes.
interface onehot_encoder8_serial_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec;
    logic [2:0] code;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       none;
    logic [3:0] count;

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, code, out_valid, out_last, none, count
    );

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, code, out_valid, out_last, none, count
    );
endinterface

// File: rtl/onehot_encoder8_serial.sv
// Serialises an 8-bit activation vector into one 3-bit decoder code per set line,
// in priority order, so each code re-decodes to exactly one active line.
module onehot_encoder8_serial #(
    parameter int LSB_FIRST = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    onehot_encoder8_serial_if.slave       bus
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic [2:0] code_q, code_d;
    logic       last_q, last_d;
    logic       none_q, none_d;
    logic [3:0] count_q, count_d;

    logic [2:0] cur_idx;
    logic [7:0] remaining;
    logic [2:0] next_idx;

    // Index of the line that goes out first from v (0 when v is empty).
    function automatic logic [2:0] pri_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        if (LSB_FIRST != 0) begin
            for (int k = 7; k >= 0; k--) begin
                if (v[k]) idx = 3'(k);
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (v[k]) idx = 3'(k);
            end
        end
        return idx;
    endfunction

    // The downstream decoder reads the line index bit-reversed.
    function automatic logic [2:0] encode(input logic [2:0] idx);
        return {idx[0], idx[1], idx[2]};
    endfunction

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int k = 0; k < 8; k++) begin
            cnt = cnt + {3'b000, v[k]};
        end
        return cnt;
    endfunction

    function automatic logic single_bit(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 8'd0;
            code_q    <= 3'd0;
            last_q    <= 1'b0;
            none_q    <= 1'b0;
            count_q   <= 4'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            last_q    <= last_d;
            none_q    <= none_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        code_d    = code_q;
        last_d    = last_q;
        none_d    = 1'b0;
        count_d   = count_q;

        cur_idx   = pri_idx(pending_q);
        remaining = pending_q & ~(8'd1 << cur_idx);
        next_idx  = pri_idx(remaining);

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    pending_d = bus.in_vec;
                    count_d   = popcount(bus.in_vec);
                    if (bus.in_vec == 8'd0) begin
                        none_d = 1'b1;
                    end else begin
                        state_d = EMIT;
                        code_d  = encode(pri_idx(bus.in_vec));
                        last_d  = single_bit(bus.in_vec);
                    end
                end
            end
            EMIT: begin
                // Code and last stay frozen until the consumer takes them.
                if (bus.out_ready) begin
                    pending_d = remaining;
                    if (last_q) begin
                        state_d = IDLE;
                        last_d  = 1'b0;
                    end else begin
                        code_d = encode(next_idx);
                        last_d = single_bit(remaining);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == EMIT);
    assign bus.out_last  = last_q;
    assign bus.code      = code_q;
    assign bus.none      = none_q;
    assign bus.count     = count_q;

endmodule
